// File: rtl/regfile_pkg.sv
// Shared constants and scanner state type for the register file and its read-side scanner.
package regfile_pkg;

   // Default geometry shared by register_file and regfile_scanner
   localparam int REG_ADDR_W = 5;
   localparam int REG_BUS_W  = 32;

   // Scanner FSM states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      SEND_A = 3'd2,
      SEND_B = 3'd3,
      DONE   = 3'd4
   } scan_state_t;

endpackage

// File: rtl/regfile_scanner_if.sv
// Valid/ready stream carrying one register value and its register number per beat.
interface regfile_scanner_if #(
   parameter int ADDR  = 5,
   parameter int BUS_W = 32
) ();

   logic             out_valid;
   logic             out_ready;
   logic [BUS_W-1:0] out_data;
   logic [ADDR-1:0]  out_idx;

   modport master (output out_valid, output out_data, output out_idx, input  out_ready);
   modport slave  (input  out_valid, input  out_data, input  out_idx, output out_ready);

endinterface

// File: rtl/register_file.sv
// MIPS-style register file: one synchronous write port, two combinational read ports.
module register_file
   import regfile_pkg::*;
#(
   parameter int ADDR  = REG_ADDR_W,
   parameter int BUS_W = REG_BUS_W
) (
   input  logic             reloj,
   input  logic             we,
   input  logic [ADDR-1:0]  rd_addr,
   input  logic [BUS_W-1:0] rd_data,
   input  logic [ADDR-1:0]  rs_addr,
   input  logic [ADDR-1:0]  rt_addr,
   output logic [BUS_W-1:0] rs_data,
   output logic [BUS_W-1:0] rt_data
);

   logic [BUS_W-1:0] regs_q [2**ADDR];

   // Write port: register rd_addr takes rd_data on the rising edge when we is high
   always_ff @(posedge reloj) begin
      if (we) begin
         regs_q[rd_addr] <= rd_data;
      end
   end

   assign rs_data = regs_q[rs_addr];
   assign rt_data = regs_q[rt_addr];

endmodule

// File: rtl/regfile_scanner.sv
// Walks every register of register_file in address order, two per read cycle,
// and streams each value out over a valid/ready interface.
module regfile_scanner
   import regfile_pkg::*;
#(
   parameter int ADDR  = REG_ADDR_W,
   parameter int BUS_W = REG_BUS_W
) (
   input  logic             reloj,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [ADDR-1:0]  rs_addr,
   output logic [ADDR-1:0]  rt_addr,
   input  logic [BUS_W-1:0] rs_data,
   input  logic [BUS_W-1:0] rt_data,
   regfile_scanner_if.master out_if
);

   // The pair counter k lives directly in the address registers:
   // rs_addr = {k,0}, rt_addr = {k,1}. Stepping k is "+2" on both, and
   // "k all ones" is "rt_addr all ones". This also covers ADDR = 1 where k is empty.
   localparam logic [ADDR-1:0] RS_FIRST = '0;
   localparam logic [ADDR-1:0] RT_FIRST = ADDR'(1);
   localparam logic [ADDR-1:0] PAIR_STEP = ADDR'(2);

   scan_state_t      state_q, state_d;
   logic [ADDR-1:0]  rs_addr_q, rs_addr_d;
   logic [ADDR-1:0]  rt_addr_q, rt_addr_d;
   logic [BUS_W-1:0] buf_a_q, buf_a_d;
   logic [BUS_W-1:0] buf_b_q, buf_b_d;
   logic             last_pair;

   assign last_pair = &rt_addr_q;

   // State, address and capture-buffer registers
   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rs_addr_q <= RS_FIRST;
         rt_addr_q <= RT_FIRST;
         buf_a_q   <= '0;
         buf_b_q   <= '0;
      end else begin
         state_q   <= state_d;
         rs_addr_q <= rs_addr_d;
         rt_addr_q <= rt_addr_d;
         buf_a_q   <= buf_a_d;
         buf_b_q   <= buf_b_d;
      end
   end

   // Next state: addresses only move on the SEND_B handshake, so stalls never re-read
   always_comb begin
      state_d   = state_q;
      rs_addr_d = rs_addr_q;
      rt_addr_d = rt_addr_q;
      buf_a_d   = buf_a_q;
      buf_b_d   = buf_b_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = ISSUE;
               rs_addr_d = RS_FIRST;
               rt_addr_d = RT_FIRST;
            end
         end
         ISSUE: begin
            // Snapshot of the pair is taken at this closing edge
            buf_a_d = rs_data;
            buf_b_d = rt_data;
            state_d = SEND_A;
         end
         SEND_A: begin
            if (out_if.out_ready) begin
               state_d = SEND_B;
            end
         end
         SEND_B: begin
            if (out_if.out_ready) begin
               if (last_pair) begin
                  state_d = DONE;
               end else begin
                  rs_addr_d = rs_addr_q + PAIR_STEP;
                  rt_addr_d = rt_addr_q + PAIR_STEP;
                  state_d   = ISSUE;
               end
            end
         end
         DONE: begin
            state_d   = IDLE;
            rs_addr_d = RS_FIRST;
            rt_addr_d = RT_FIRST;
         end
         default: begin
            state_d   = IDLE;
            rs_addr_d = RS_FIRST;
            rt_addr_d = RT_FIRST;
         end
      endcase
   end

   // Outputs decode from registered state only; out_valid never looks at out_ready
   always_comb begin
      out_if.out_valid = 1'b0;
      out_if.out_data  = buf_a_q;
      out_if.out_idx   = rs_addr_q;
      busy             = (state_q != IDLE);
      done             = (state_q == DONE);
      if (state_q == SEND_A) begin
         out_if.out_valid = 1'b1;
      end else if (state_q == SEND_B) begin
         out_if.out_valid = 1'b1;
         out_if.out_data  = buf_b_q;
         out_if.out_idx   = rt_addr_q;
      end
   end

   assign rs_addr = rs_addr_q;
   assign rt_addr = rt_addr_q;

endmodule

// File: doc/regfile_scanner.md
# regfile_scanner

Read-side initiator for the MIPS-style `register_file`. On a start pulse it walks every architectural register in address order. It drives the register file's two read ports (`rs_addr`/`rt_addr`) with consecutive address pairs, captures `rs_data`/`rt_data`, and streams each register value out over a valid/ready interface. It is used for debug dumps, context save and bench-side state checking, and sits beside the datapath with its address outputs muxed onto the register file's read ports.

## Interface
- `ADDR`, 5, register address width; register count is 2^ADDR; must be ≥ 1.
- `BUS_W`, 32, register data width.
- `reloj`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a scan; ignored while `busy`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the last register has been accepted downstream.
- `rs_addr`  out  ADDR  read address to register file port A (even registers).
- `rt_addr`  out  ADDR  read address to register file port B (odd registers).
- `rs_data`  in  BUS_W  port A read data; combinational from `rs_addr`.
- `rt_data`  in  BUS_W  port B read data; combinational from `rt_addr`.
- `out_valid`  out  1  `out_data`/`out_idx` hold a register value.
- `out_ready`  in  1  downstream accepts the value on an edge where `out_valid && out_ready`.
- `out_data`  out  BUS_W  register value.
- `out_idx`  out  ADDR  register number of `out_data`.

## Operation
- FSM states: IDLE, ISSUE, SEND_A, SEND_B, DONE.
- Pair counter `k` is ADDR-1 bits wide (0 when ADDR = 1).
  - `rs_addr = {k,1'b0}`, `rt_addr = {k,1'b1}`, both registered.
- IDLE + `start` → ISSUE with `k = 0`, `busy = 1`.
- ISSUE, which always lasts 1 cycle:
  - Addresses are stable for the whole cycle.
  - At the closing edge, `rs_data` → buffer A and `rt_data` → buffer B.
  - Transition → SEND_A.
- SEND_A:
  - `out_valid = 1`, `out_data = A`, `out_idx = 2k`.
  - Holds until handshake, then → SEND_B.
- SEND_B:
  - `out_valid = 1`, `out_data = B`, `out_idx = 2k+1`.
  - On handshake: if `k` is all-ones → DONE; else `k` increments (wrap-free), the new addresses are driven, and → ISSUE.
- DONE, which lasts 1 cycle: `done = 1`, `busy` stays 1, `out_valid = 0`. Transition → IDLE, which clears `busy` and sets `k = 0`.
- AXI-style stream rules:
  - While `out_valid` is high and not accepted, `out_data`/`out_idx` are stable.
  - `out_valid` never depends combinationally on `out_ready`.
- Snapshot semantics: each pair is sampled at its ISSUE edge. Writes through `rd_addr` during a scan are visible only for pairs not yet issued.
- Register 0 is scanned like any other register; no special casing.
- `start` is ignored in every state other than IDLE, including DONE.

## Timing
- Reset values: `busy = 0`, `done = 0`, `out_valid = 0`, `out_data = 0`, `out_idx = 0`, `rs_addr = 0`, `rt_addr = 1`, state IDLE, buffers 0.
- `start` high at edge N:
  - ISSUE occupies cycle N..N+1.
  - `out_valid` first rises after edge N+1.
- Cost per pair: 3 cycles minimum with `out_ready` tied high.
- Full scan at ADDR = 5: 16 pairs → 48 cycles from the `start` edge to the last handshake, and `done` is high in the following cycle.
- Reset asserted mid-scan:
  - All outputs go to reset values immediately (asynchronous).
  - No `done` is produced, and a partial stream is discarded.
- Back-pressure in SEND_A/SEND_B holds the register file addresses unchanged, so no re-read occurs.

## Structure
- Shared package `regfile_pkg`:
  - Default `ADDR`/`BUS_W` constants shared with `register_file`.
  - The scanner state enum `scan_state_t`.
- Single module, no sub-module: the FSM, pair counter and two capture buffers are inline.
- The bench instantiates `register_file` and `regfile_scanner` back-to-back.

## Test plan
- Preload register r = 32'hA5A5_0000 + r. `start`, `out_ready = 1`:
  - 32 beats, `out_idx` 0..31, matching data.
  - `done` high exactly one cycle, at cycle 49 after `start`.
- Same preload, with `out_ready` toggled randomly 50%:
  - Identical beat sequence.
  - `out_data`/`out_idx` stable across every stalled cycle.
  - `rs_addr`/`rt_addr` unchanged while stalled.
- `start` pulsed again while `busy` (and during DONE): no restart, still exactly 32 beats and one `done`.
- Write r20 = 32'hDEAD_BEEF after beat idx 5 and before pair 10 issues: beat 20 shows 32'hDEAD_BEEF. Write r2 at the same time: beat 2 keeps the old value.
- Assert `reset` after beat 11 while stalled:
  - `out_valid`, `busy` and `done` drop the same cycle; `rs_addr = 0`, `rt_addr = 1`.
  - A new `start` produces a full scan from idx 0.
- ADDR = 1: 2 beats (idx 0, 1), then `done` on the 4th cycle after `start`.
